// File: rtl/debounce_pkg.sv
// debounce_pkg: types and helpers shared by the debounce bank RTL and its bench.
//   cnt_w(max_val) : bit width needed to hold 0..max_val (never less than 1)
//   event_e        : per-channel event classification used by the bench scoreboard
package debounce_pkg;

    // Width of a counter that must reach max_val without wrapping.
    // A zero max still needs one bit so the declaration stays legal.
    function automatic int cnt_w(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

    typedef enum logic [1:0] {
        EV_NONE,
        EV_RISE,
        EV_FALL
    } event_e;

endpackage

// File: rtl/debounce_if.sv
// debounce_if: groups the per-channel level/event vectors of a debounce bank.
//   din  : raw asynchronous inputs            (master -> slave)
//   dout : debounced levels                   (slave -> master)
//   rise : one-cycle pulse on dout 0->1       (slave -> master)
//   fall : one-cycle pulse on dout 1->0       (slave -> master)
//   hold : one-cycle long-press/repeat pulse  (slave -> master)
// The slave modport is the filter; the master modport is whoever owns the pins.
interface debounce_if #(
    parameter int N_CH = 4
) ();

    logic [N_CH-1:0] din;
    logic [N_CH-1:0] dout;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] hold;

    modport master (
        output din,
        input  dout,
        input  rise,
        input  fall,
        input  hold
    );

    modport slave (
        input  din,
        output dout,
        output rise,
        output fall,
        output hold
    );

endinterface

// File: rtl/debounce_chan.sv
// debounce_chan: one debounce channel.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   tick   : shared prescaler strobe; counters only advance when it is high
//   din_i  : raw asynchronous input
//   dout_o : debounced level
//   rise_o : one-cycle pulse when dout goes 0->1
//   fall_o : one-cycle pulse when dout goes 1->0
//   hold_o : one-cycle long-press pulse, then repeat pulses (if enabled)
// The input passes a SYNC_STAGES flop synchroniser. The synchronised value is
// tracked as a candidate level; once the candidate has been stable for
// COUNT_MAX+1 ticks it is copied to dout.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   COUNT_MAX   = 255,
    parameter int   HOLD_MAX    = 0,
    parameter int   REPEAT_MAX  = 0,
    parameter logic INIT_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic din_i,
    output logic dout_o,
    output logic rise_o,
    output logic fall_o,
    output logic hold_o
);

    localparam int              CNT_W     = cnt_w(COUNT_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX_V = CNT_W'(COUNT_MAX);

    // ------------------------------------------------------------------
    // Synchroniser chain; stage 0 samples the raw pin.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s;

    assign sync_d[0] = din_i;
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
        assign sync_d[gi] = sync_q[gi-1];
    end
    assign s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Candidate / stability counter / debounced level
    // ------------------------------------------------------------------
    logic             cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             dout_q, dout_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s != cand_q) begin
            // A new level restarts the stability window even between ticks,
            // so a bounce can never sneak through on a slow tick.
            cand_d = s;
            cnt_d  = '0;
        end else if (tick) begin
            if (cnt_q != CNT_MAX_V) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (dout_q != cand_q) begin
                dout_d = cand_q;
                rise_d = cand_q;
                fall_d = ~cand_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {SYNC_STAGES{INIT_LEVEL}};
            cand_q <= INIT_LEVEL;
            cnt_q  <= '0;
            dout_q <= INIT_LEVEL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dout_o = dout_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

    // ------------------------------------------------------------------
    // Long-press / auto-repeat
    // ------------------------------------------------------------------
    if (HOLD_MAX > 0) begin : g_hold
        localparam int               HCNT_W = cnt_w(HOLD_MAX);
        localparam logic [HCNT_W-1:0] HOLD_V = HCNT_W'(HOLD_MAX);
        // After a pulse the counter restarts REPEAT_MAX below the threshold so
        // the next pulse lands REPEAT_MAX ticks later. With repeat disabled it
        // parks at the threshold and stays silent. A repeat period longer than
        // the initial hold cannot be represented, so it falls back to HOLD_MAX.
        localparam int RELOAD = (REPEAT_MAX == 0)        ? HOLD_MAX :
                                (REPEAT_MAX >= HOLD_MAX) ? 0        :
                                                           HOLD_MAX - REPEAT_MAX;
        localparam logic [HCNT_W-1:0] RELOAD_V = HCNT_W'(RELOAD);

        logic [HCNT_W-1:0] hcnt_q, hcnt_d;
        logic              hold_q, hold_d;

        always_comb begin
            hcnt_d = hcnt_q;
            hold_d = 1'b0;
            // fall_d covers the release cycle itself, so a repeat pulse that
            // would coincide with the falling edge is dropped.
            if (!dout_q || fall_d) begin
                hcnt_d = '0;
            end else if (tick && (hcnt_q != HOLD_V)) begin
                if (hcnt_q == HOLD_V - HCNT_W'(1)) begin
                    hold_d = 1'b1;
                    hcnt_d = RELOAD_V;
                end else begin
                    hcnt_d = hcnt_q + HCNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                hcnt_q <= '0;
                hold_q <= 1'b0;
            end else begin
                hcnt_q <= hcnt_d;
                hold_q <= hold_d;
            end
        end

        assign hold_o = hold_q;
    end else begin : g_no_hold
        assign hold_o = 1'b0;
    end

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: N_CH independent debounce channels sharing one tick prescaler.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : debounce_if slave port (din in; dout/rise/fall/hold out)
// The prescaler lets long debounce times use narrow per-channel counters:
// every channel counter only advances on the common tick.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int   N_CH        = 4,
    parameter int   SYNC_STAGES = 2,
    parameter int   TICK_DIV    = 1,
    parameter int   COUNT_MAX   = 255,
    parameter int   HOLD_MAX    = 0,
    parameter int   REPEAT_MAX  = 0,
    parameter logic INIT_LEVEL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    debounce_if.slave  bus
);

    logic tick;

    // ------------------------------------------------------------------
    // Shared prescaler: tick is high during the last count of each period.
    // ------------------------------------------------------------------
    if (TICK_DIV > 1) begin : g_presc
        localparam int               PCNT_W = cnt_w(TICK_DIV - 1);
        localparam logic [PCNT_W-1:0] LAST_V = PCNT_W'(TICK_DIV - 1);

        logic [PCNT_W-1:0] pcnt_q, pcnt_d;

        always_comb begin
            pcnt_d = pcnt_q + PCNT_W'(1);
            if (pcnt_q == LAST_V) begin
                pcnt_d = '0;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                pcnt_q <= '0;
            end else begin
                pcnt_q <= pcnt_d;
            end
        end

        assign tick = (pcnt_q == LAST_V);
    end else begin : g_no_presc
        assign tick = 1'b1;
    end

    // ------------------------------------------------------------------
    // Channel array
    // ------------------------------------------------------------------
    logic [N_CH-1:0] dout_w;
    logic [N_CH-1:0] rise_w;
    logic [N_CH-1:0] fall_w;
    logic [N_CH-1:0] hold_w;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
        debounce_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .COUNT_MAX   (COUNT_MAX),
            .HOLD_MAX    (HOLD_MAX),
            .REPEAT_MAX  (REPEAT_MAX),
            .INIT_LEVEL  (INIT_LEVEL)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .tick   (tick),
            .din_i  (bus.din[gi]),
            .dout_o (dout_w[gi]),
            .rise_o (rise_w[gi]),
            .fall_o (fall_w[gi]),
            .hold_o (hold_w[gi])
        );
    end

    assign bus.dout = dout_w;
    assign bus.rise = rise_w;
    assign bus.fall = fall_w;
    assign bus.hold = hold_w;

endmodule
